// File: rtl/adc2fifo.sv
// -----------------------------------------------------------------------------
// adc2fifo
//   Receive-side deframer for the ADC byte link. It checks the 55 AA header,
//   captures the info, sample-rate and kind bytes, and reassembles big-endian
//   16-bit words into the downstream sample FIFO. It then checks the trailing
//   8-bit checksum and reports a status word when rx_en drops.
//
//   Frame: 55 AA info smpr kind D0 D1 ... Dn-1 CS,  CS = sum(D) mod 256
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   rx_en       high for every byte of one frame
//   rx_d        frame byte, sampled while rx_en = 1
//   fifo_full   downstream sample FIFO full
//   word_d      reassembled word {high, low}
//   word_wr     one-cycle write strobe for word_d
//   dev_info    info byte of the most recent header
//   dev_smpr    sample-rate byte of the most recent header
//   dev_kind    kind byte of the most recent header
//   word_cnt    words accepted in the current / last frame (saturating)
//   frame_done  one-cycle end-of-frame pulse
//   frame_ok    with frame_done: no error bits set
//   err         sticky per-frame errors
//               [0] bad header  [1] short frame  [2] odd data count
//               [3] checksum    [4] overflow
//
// State table
//   state | meaning
//   IDLE  | waiting for rx_en; first byte must be 0x55
//   HD01  | second header byte, must be 0xAA
//   DIFO  | capture info byte
//   DSPR  | capture sample-rate byte
//   DTYE  | capture kind byte
//   DATA  | payload bytes through the one-byte holding register
//   DROP  | discard bytes until rx_en falls
//   DONE  | frame_done pulse, status stable
// -----------------------------------------------------------------------------
module adc2fifo #(
   parameter logic [15:0] MAX_WORDS = 16'd1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_en,
   input  logic [7:0]  rx_d,
   input  logic        fifo_full,
   output logic [15:0] word_d,
   output logic        word_wr,
   output logic [7:0]  dev_info,
   output logic [7:0]  dev_smpr,
   output logic [7:0]  dev_kind,
   output logic [15:0] word_cnt,
   output logic        frame_done,
   output logic        frame_ok,
   output logic [4:0]  err
);

   typedef enum logic [2:0] {
      IDLE, HD01, DIFO, DSPR, DTYE, DATA, DROP, DONE
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  err_nxt;
   logic [15:0] cnt_nxt;
   logic [7:0]  sum, sum_nxt;
   logic        par, par_nxt;
   logic [7:0]  hold, hold_nxt;
   logic        hold_v, hold_v_nxt;
   logic [7:0]  hi_byte, hi_nxt;
   logic [15:0] wd_nxt;
   logic        wr_nxt;
   logic [7:0]  info_nxt, smpr_nxt, kind_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         err      <= 5'd0;
         word_cnt <= 16'd0;
         sum      <= 8'd0;
         par      <= 1'b0;
         hold     <= 8'd0;
         hold_v   <= 1'b0;
         hi_byte  <= 8'd0;
         word_d   <= 16'd0;
         word_wr  <= 1'b0;
         dev_info <= 8'd0;
         dev_smpr <= 8'd0;
         dev_kind <= 8'd0;
      end else begin
         state    <= state_nxt;
         err      <= err_nxt;
         word_cnt <= cnt_nxt;
         sum      <= sum_nxt;
         par      <= par_nxt;
         hold     <= hold_nxt;
         hold_v   <= hold_v_nxt;
         hi_byte  <= hi_nxt;
         word_d   <= wd_nxt;
         word_wr  <= wr_nxt;
         dev_info <= info_nxt;
         dev_smpr <= smpr_nxt;
         dev_kind <= kind_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      err_nxt    = err;
      cnt_nxt    = word_cnt;
      sum_nxt    = sum;
      par_nxt    = par;
      hold_nxt   = hold;
      hold_v_nxt = hold_v;
      hi_nxt     = hi_byte;
      wd_nxt     = word_d;
      wr_nxt     = 1'b0;
      info_nxt   = dev_info;
      smpr_nxt   = dev_smpr;
      kind_nxt   = dev_kind;

      case (state)
         IDLE: begin
            if (rx_en) begin
               err_nxt    = 5'd0;
               cnt_nxt    = 16'd0;
               sum_nxt    = 8'd0;
               par_nxt    = 1'b0;
               hold_v_nxt = 1'b0;
               if (rx_d == 8'h55) begin
                  state_nxt = HD01;
               end else begin
                  err_nxt   = 5'b00001;
                  state_nxt = DROP;
               end
            end
         end
         HD01: begin
            if (!rx_en) begin
               err_nxt[1] = 1'b1;
               state_nxt  = DONE;
            end else if (rx_d == 8'hAA) begin
               state_nxt = DIFO;
            end else begin
               err_nxt[0] = 1'b1;
               state_nxt  = DROP;
            end
         end
         DIFO: begin
            if (!rx_en) begin
               err_nxt[1] = 1'b1;
               state_nxt  = DONE;
            end else begin
               info_nxt  = rx_d;
               state_nxt = DSPR;
            end
         end
         DSPR: begin
            if (!rx_en) begin
               err_nxt[1] = 1'b1;
               state_nxt  = DONE;
            end else begin
               smpr_nxt  = rx_d;
               state_nxt = DTYE;
            end
         end
         DTYE: begin
            if (!rx_en) begin
               err_nxt[1] = 1'b1;
               state_nxt  = DONE;
            end else begin
               kind_nxt  = rx_d;
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (rx_en) begin
               // A new byte proves the held one was payload, not the checksum.
               if (hold_v) begin
                  sum_nxt = sum + hold;
                  par_nxt = ~par;
                  if (!par) begin
                     hi_nxt = hold;
                  end else if (word_cnt == MAX_WORDS) begin
                     err_nxt[4] = 1'b1;
                  end else if (fifo_full) begin
                     // Word is lost but still counted as received.
                     err_nxt[4] = 1'b1;
                     cnt_nxt    = word_cnt + 16'd1;
                  end else begin
                     wr_nxt  = 1'b1;
                     wd_nxt  = {hi_byte, hold};
                     cnt_nxt = word_cnt + 16'd1;
                  end
               end
               hold_nxt   = rx_d;
               hold_v_nxt = 1'b1;
            end else begin
               // hold now carries the checksum byte.
               if (!hold_v) begin
                  err_nxt[1] = 1'b1;
               end else begin
                  if (hold != sum) err_nxt[3] = 1'b1;
                  if (par)         err_nxt[2] = 1'b1;
               end
               state_nxt = DONE;
            end
         end
         DROP: begin
            if (!rx_en) state_nxt = DONE;
         end
         DONE: begin
            if (rx_en) begin
               // Frame started without a gap: not parsed, reported as bad header.
               err_nxt   = 5'b00001;
               cnt_nxt   = 16'd0;
               state_nxt = DROP;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign frame_done = (state == DONE);
   assign frame_ok   = frame_done && (err == 5'd0);

endmodule

// File: tb/tb_adc2fifo.sv
module tb_adc2fifo;

   typedef struct packed {
      logic [4:0]  err;
      logic [15:0] cnt;
      logic [7:0]  info;
      logic [7:0]  smpr;
      logic [7:0]  kind;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_en = 1'b0;
   logic [7:0]  rx_d = 8'd0;
   logic        fifo_full = 1'b0;

   logic [15:0] wd [2];
   logic        wwr [2];
   logic [7:0]  dinf [2];
   logic [7:0]  dsmp [2];
   logic [7:0]  dknd [2];
   logic [15:0] wcnt [2];
   logic        fdone [2];
   logic        fok [2];
   logic [4:0]  ferr [2];

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_w [2][$];
   frame_t      exp_f [2][$];
   logic [7:0]  m_info [2];
   logic [7:0]  m_smpr [2];
   logic [7:0]  m_kind [2];

   logic [7:0]  frm_b [$];
   bit          frm_ff [$];

   always #5 clk = ~clk;

   adc2fifo #(.MAX_WORDS(16'd1024)) u_dut (
      .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx_d(rx_d), .fifo_full(fifo_full),
      .word_d(wd[0]), .word_wr(wwr[0]), .dev_info(dinf[0]), .dev_smpr(dsmp[0]),
      .dev_kind(dknd[0]), .word_cnt(wcnt[0]), .frame_done(fdone[0]),
      .frame_ok(fok[0]), .err(ferr[0])
   );

   adc2fifo #(.MAX_WORDS(16'd1)) u_max1 (
      .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx_d(rx_d), .fifo_full(fifo_full),
      .word_d(wd[1]), .word_wr(wwr[1]), .dev_info(dinf[1]), .dev_smpr(dsmp[1]),
      .dev_kind(dknd[1]), .word_cnt(wcnt[1]), .frame_done(fdone[1]),
      .frame_ok(fok[1]), .err(ferr[1])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Reference: parse the whole frame from its byte list.
   task automatic model(input int inst);
      logic [4:0] e;
      int         cnt, maxw, n, nd, idx;
      logic [7:0] s;
      frame_t     f;
      n    = frm_b.size();
      maxw = (inst == 0) ? 1024 : 1;
      e    = 5'd0;
      cnt  = 0;
      if (frm_b[0] != 8'h55) e[0] = 1'b1;
      else if (n < 2) e[1] = 1'b1;
      else if (frm_b[1] != 8'hAA) e[0] = 1'b1;
      else begin
         if (n >= 3) m_info[inst] = frm_b[2];
         if (n >= 4) m_smpr[inst] = frm_b[3];
         if (n >= 5) m_kind[inst] = frm_b[4];
         if (n < 6) e[1] = 1'b1;
         else begin
            nd = n - 6;
            s  = 8'd0;
            for (int i = 0; i < nd; i++) s = s + frm_b[5+i];
            if (s != frm_b[n-1]) e[3] = 1'b1;
            if (nd % 2 == 1) e[2] = 1'b1;
            for (int j = 0; j < nd / 2; j++) begin
               idx = 7 + 2 * j;   // byte whose arrival completes word j
               if (cnt == maxw) e[4] = 1'b1;
               else begin
                  if (frm_ff[idx]) e[4] = 1'b1;
                  else exp_w[inst].push_back({frm_b[5+2*j], frm_b[6+2*j]});
                  cnt++;
               end
            end
         end
      end
      f.err  = e;
      f.cnt  = 16'(cnt);
      f.info = m_info[inst];
      f.smpr = m_smpr[inst];
      f.kind = m_kind[inst];
      exp_f[inst].push_back(f);
   endtask

   task automatic drive(input logic en, input logic [7:0] d, input logic ff);
      @(posedge clk);
      #1;
      rx_en     = en;
      rx_d      = d;
      fifo_full = ff;
   endtask

   task automatic gap(input int g);
      for (int i = 0; i < g; i++) drive(1'b0, 8'($urandom), 1'b0);
   endtask

   task automatic run_frame(input int g);
      model(0);
      model(1);
      for (int i = 0; i < frm_b.size(); i++) drive(1'b1, frm_b[i], frm_ff[i]);
      gap(g);
   endtask

   task automatic ff_zero();
      frm_ff.delete();
      for (int i = 0; i < frm_b.size(); i++) frm_ff.push_back(1'b0);
   endtask

   task automatic check_zero(input string name, input int inst);
      check(name, {wd[inst], wwr[inst], dinf[inst], dsmp[inst], dknd[inst],
                   wcnt[inst], fdone[inst], fok[inst], ferr[inst]}, 64'd0);
   endtask

   // Monitor: pops expectations whenever a DUT presents a word or a frame end.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            if (wwr[k]) begin
               if (exp_w[k].size() == 0) begin
                  checks++; errors++;
                  $display("FAIL word%0d unexpected act=%0h exp=none", k, wd[k]);
               end else begin
                  check($sformatf("word%0d", k), 64'(wd[k]), 64'(exp_w[k].pop_front()));
               end
            end
            if (fdone[k]) begin
               if (exp_f[k].size() == 0) begin
                  checks++; errors++;
                  $display("FAIL frame%0d unexpected err=%0h exp=none", k, ferr[k]);
               end else begin
                  frame_t f;
                  f = exp_f[k].pop_front();
                  check($sformatf("err%0d", k), 64'(ferr[k]), 64'(f.err));
                  check($sformatf("word_cnt%0d", k), 64'(wcnt[k]), 64'(f.cnt));
                  check($sformatf("frame_ok%0d", k), 64'(fok[k]), 64'(f.err == 5'd0));
                  check($sformatf("dev%0d", k), {40'd0, dinf[k], dsmp[k], dknd[k]},
                        {40'd0, f.info, f.smpr, f.kind});
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int         n;
      logic [7:0] s;
      for (int k = 0; k < 2; k++) begin
         m_info[k] = 8'd0; m_smpr[k] = 8'd0; m_kind[k] = 8'd0;
      end
      #12;
      check_zero("reset0", 0);
      check_zero("reset1", 1);
      #3;
      rst_n = 1'b1;
      gap(2);

      // nominal
      frm_b = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
      ff_zero();
      run_frame(3);
      // checksum error
      frm_b[9] = 8'h15;
      run_frame(2);
      // bad header
      frm_b = '{8'h54, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h12, 8'h34, 8'h00};
      ff_zero();
      run_frame(2);
      // odd data count
      frm_b = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h12, 8'h34, 8'h56, 8'h9C};
      ff_zero();
      run_frame(2);
      // fifo_full during the first word
      frm_b = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
      ff_zero();
      frm_ff[7] = 1'b1;
      frm_ff[8] = 1'b1;
      run_frame(2);
      // short frames
      frm_b = '{8'h55, 8'hAA, 8'h07, 8'h08};
      ff_zero();
      run_frame(2);
      frm_b = '{8'h55};
      ff_zero();
      run_frame(2);
      frm_b = '{8'h55, 8'hAA, 8'h09, 8'h0A, 8'h0B};
      ff_zero();
      run_frame(2);

      // reset mid-frame after byte 12
      frm_b = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h12};
      for (int i = 0; i < frm_b.size(); i++) drive(1'b1, frm_b[i], 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero("midreset0", 0);
      check_zero("midreset1", 1);
      for (int k = 0; k < 2; k++) begin
         m_info[k] = 8'd0; m_smpr[k] = 8'd0; m_kind[k] = 8'd0;
      end
      frm_b = '{8'h34, 8'h56, 8'h78, 8'h14};
      ff_zero();
      model(0);
      model(1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rx_en = 1'b1;
      rx_d  = 8'h34;
      for (int i = 1; i < frm_b.size(); i++) drive(1'b1, frm_b[i], 1'b0);
      gap(2);
      frm_b = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
      ff_zero();
      run_frame(2);

      // randomized frames
      for (int t = 0; t < 200; t++) begin
         n = int'($urandom_range(1, 24));
         frm_b.delete();
         frm_ff.delete();
         for (int i = 0; i < n; i++) begin
            frm_b.push_back(8'($urandom));
            frm_ff.push_back($urandom_range(0, 3) == 0);
         end
         if ($urandom_range(0, 7) != 0) frm_b[0] = 8'h55;
         if (n > 1 && $urandom_range(0, 7) != 0) frm_b[1] = 8'hAA;
         if (n > 6 && $urandom_range(0, 3) != 0) begin
            s = 8'd0;
            for (int i = 5; i < n - 1; i++) s = s + frm_b[i];
            frm_b[n-1] = s;
         end
         run_frame(int'($urandom_range(2, 4)));
      end

      gap(5);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("words_left%0d", k), 64'(exp_w[k].size()), 64'd0);
         check($sformatf("frames_left%0d", k), 64'(exp_f[k].size()), 64'd0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
